// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers, holding off a full
// frame after every start pulse. Define UART_ARB_LOCK_EN to let a requester keep the grant.
module uart_tx_arbiter #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int BAUD_RATE       = 115200,
    parameter int NUM_REQ         = 4,
    parameter int FRAME_CYCLES    = 12 * (CLOCK_FREQUENCY / BAUD_RATE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_lock,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic [2:0]             grant_id
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [IDX_W-1:0]   grant_idx_reg;
    logic [7:0]         tx_data_reg;
    logic               tx_start_reg;
    logic               busy_reg;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic [NUM_REQ-1:0] eligible;
    logic [7:0]         data_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[8*gi +: 8];
        end
    endgenerate

`ifdef UART_ARB_LOCK_EN
    // Lock is sampled when the hold-off ends; a dropped lock is seen one IDLE cycle later.
    logic lock_hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_hold_reg <= 1'b0;
        end else if (state_reg == S_WAIT && cnt_reg <= CNT_LAST) begin
            lock_hold_reg <= req_lock[grant_idx_reg];
        end else if (state_reg == S_IDLE && (pick_found || !req_lock[grant_idx_reg])) begin
            lock_hold_reg <= 1'b0;
        end
    end

    always_comb begin
        eligible = req_valid;
        if (lock_hold_reg) begin
            eligible = '0;
            eligible[grant_idx_reg] = req_valid[grant_idx_reg];
        end
    end
`else
    logic lock_unused;
    assign lock_unused = |req_lock;
    assign eligible    = req_valid;
`endif

    // Search starts just after the last grant, so the pointer wraps naturally.
    always_comb begin
        logic [IDX_W-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_reg == S_IDLE && pick_found) begin
            req_ready[pick_idx] = 1'b1;
        end
    end

    // Reset lands in WAIT so a frame launched just before reset can still finish on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_WAIT;
            cnt_reg       <= CNT_LOAD;
            ptr_reg       <= IDX_W'(NUM_REQ - 1);
            grant_idx_reg <= '0;
            tx_data_reg   <= 8'h00;
            tx_start_reg  <= 1'b0;
            busy_reg      <= 1'b1;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_idx_reg <= pick_idx;
                        ptr_reg       <= pick_idx;
                        tx_data_reg   <= data_arr[pick_idx];
                        tx_start_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt_reg   <= CNT_LOAD;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_reg <= CNT_LAST) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_LAST;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start = tx_start_reg;
    assign tx_data  = tx_data_reg;
    assign busy     = busy_reg;
    assign grant_id = 3'(grant_idx_reg);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected frames, a negedge monitor checks them.
module tb_uart_tx_arbiter;
    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 250;
    localparam int NREQ   = 4;
    localparam int F      = 12 * (CLK_HZ / BAUD);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_lock = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              busy;
    logic [2:0]        grant_id;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int next_idle = 0;

    typedef struct {
        logic [7:0] data;
        logic [2:0] gid;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    uart_tx_arbiter #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE(BAUD),
        .NUM_REQ(NREQ)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_ready(req_ready),
        .req_lock(req_lock),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every start pulse must match the oldest expected frame, including its cycle.
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tx: tx_data=%02h grant_id=%0d at cycle %0d, none expected",
                         tx_data, grant_id, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (tx_data !== mon_e.data || grant_id !== mon_e.gid || cyc != mon_e.cyc) begin
                    fails++;
                    $display("FAIL tx_frame: got data=%02h id=%0d cycle=%0d, expected data=%02h id=%0d cycle=%0d",
                             tx_data, grant_id, cyc, mon_e.data, mon_e.gid, mon_e.cyc);
                end else begin
                    $display("[TB] tx data=%02h id=%0d cycle=%0d", tx_data, grant_id, cyc);
                end
            end
        end
        if (rst_n && req_ready != '0) begin
            tests++;
            if (!$onehot(req_ready) || (req_ready & ~req_valid) != '0 || busy !== 1'b0) begin
                fails++;
                $display("FAIL ready_rule: req_ready=%b req_valid=%b busy=%b, expected one-hot subset of valid with busy=0",
                         req_ready, req_valid, busy);
            end
        end
    end

    task automatic check_reset(input string name);
        tests++;
        if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'h00 || grant_id !== 3'd0 || req_ready !== '0) begin
            fails++;
            $display("FAIL %s: tx_start=%b busy=%b tx_data=%02h grant_id=%0d req_ready=%b, expected 0 1 00 0 0000",
                     name, tx_start, busy, tx_data, grant_id, req_ready);
        end else begin
            $display("[TB] %s ok", name);
        end
    endtask

    // Expects the next grant exactly when the arbiter returns to IDLE; queues the frame it should launch.
    task automatic grant(input logic [NREQ-1:0] exp_ready, input logic [2:0] gid,
                         input logic [7:0] data, input logic [NREQ-1:0] drop);
        int exp_cyc;
        bit seen;
        exp_cyc   = next_idle;
        sb.push_back('{data, gid, exp_cyc + 1});
        next_idle = exp_cyc + F + 1;
        seen      = 1'b0;
        for (int i = 0; i < 3 * F && !seen; i++) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL grant_timeout: no req_ready within %0d cycles, expected %b at cycle %0d",
                     3 * F, exp_ready, exp_cyc);
        end else begin
            if (req_ready !== exp_ready || cyc != exp_cyc) begin
                fails++;
                $display("FAIL grant: req_ready=%b at cycle %0d, expected %b at cycle %0d",
                         req_ready, cyc, exp_ready, exp_cyc);
            end else begin
                $display("[TB] grant ready=%b cycle=%0d", req_ready, cyc);
            end
            @(posedge clk);
            #1;
            req_valid = req_valid & ~drop;
        end
    endtask

    initial begin
        int cnt_ready;

        repeat (3) @(negedge clk);
        check_reset("reset_state");

        // Single requester right after reset: first grant only after the full guard.
        rst_n         = 1'b1;
        req_valid     = 4'b0001;
        req_data[7:0] = 8'h55;
        next_idle     = cyc + F - 1;
        grant(4'b0001, 3'd0, 8'h55, 4'b0001);

        // Reset in the middle of WAIT, then two simultaneous requesters.
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset("reset_async");
        repeat (3) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        rst_n           = 1'b1;
        req_valid       = 4'b0101;
        req_data[7:0]   = 8'hA1;
        req_data[23:16] = 8'hB2;
        next_idle       = cyc + F - 1;
        grant(4'b0001, 3'd0, 8'hA1, 4'b0001);
        grant(4'b0100, 3'd2, 8'hB2, 4'b0100);

        // Requester 1 pulses valid while the arbiter is still holding off.
        repeat (5) @(negedge clk);
        req_data[15:8] = 8'hEE;
        req_valid[1]   = 1'b1;
        cnt_ready      = 0;
        repeat (15) begin
            @(negedge clk);
            if (req_ready != '0) cnt_ready++;
        end
        req_valid[1] = 1'b0;
        tests++;
        if (cnt_ready != 0) begin
            fails++;
            $display("FAIL wait_toggle: req_ready high for %0d cycles during WAIT, expected 0", cnt_ready);
        end else begin
            $display("[TB] wait_toggle ok");
        end

        // All requesters valid: rotation continues from the last grant (2) and wraps.
        req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        req_valid = 4'b1111;
        grant(4'b1000, 3'd3, 8'hC3, 4'b0000);
        grant(4'b0001, 3'd0, 8'hC0, 4'b0000);
        grant(4'b0010, 3'd1, 8'hC1, 4'b0000);
        grant(4'b0100, 3'd2, 8'hC2, 4'b0000);
        grant(4'b1000, 3'd3, 8'hC3, 4'b0000);
        grant(4'b0001, 3'd0, 8'hC0, 4'b1111);

        // Requester 1 streams three bytes with lock held while requester 0 stays valid.
        req_data[7:0]  = 8'hD0;
        req_data[15:8] = 8'h10;
        req_lock       = 4'b0010;
        req_valid      = 4'b0011;
`ifdef UART_ARB_LOCK_EN
        grant(4'b0010, 3'd1, 8'h10, 4'b0000);
        req_data[15:8] = 8'h11;
        grant(4'b0010, 3'd1, 8'h11, 4'b0000);
        req_data[15:8] = 8'h12;
        grant(4'b0010, 3'd1, 8'h12, 4'b0010);
        req_lock = 4'b0000;
        grant(4'b0001, 3'd0, 8'hD0, 4'b0001);
`else
        grant(4'b0010, 3'd1, 8'h10, 4'b0000);
        req_data[15:8] = 8'h11;
        grant(4'b0001, 3'd0, 8'hD0, 4'b0000);
        grant(4'b0010, 3'd1, 8'h11, 4'b0000);
        req_data[15:8] = 8'h12;
        grant(4'b0001, 3'd0, 8'hD0, 4'b0000);
        grant(4'b0010, 3'd1, 8'h12, 4'b0010);
        req_lock = 4'b0000;
        grant(4'b0001, 3'd0, 8'hD0, 4'b0001);
`endif

        for (int i = 0; i < 3 * F && sb.size() != 0; i++) @(negedge clk);
        repeat (2 * F) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d expected frames never launched, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
